// File: rtl/ccip_receiver_pkg.sv
// ccip_receiver_pkg
//   Shared definitions for the CCI-P RPC receiver: the minimal CCI-P c0
//   channel types the receiver touches, the RPC record (RpcIf), the
//   rx-slot flag bit index and the read-outstanding limit.
//   No ports (package).
package ccip_receiver_pkg;

  // ---------------- CCI-P c0 channel subset ----------------
  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [15:0] t_ccip_mdata;

  typedef enum logic [1:0] {
    eVC_VA  = 2'h0,
    eVC_VL0 = 2'h1,
    eVC_VH0 = 2'h2,
    eVC_VH1 = 2'h3
  } t_ccip_vc;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'h0,
    eCL_LEN_2 = 2'h1,
    eCL_LEN_4 = 2'h3
  } t_ccip_clLen;

  typedef enum logic [3:0] {
    eREQ_RDLINE_I = 4'h0,
    eREQ_RDLINE_S = 4'h1
  } t_ccip_c0_req;

  typedef enum logic [3:0] {
    eRSP_RDLINE = 4'h0,
    eRSP_UMSG   = 4'h4
  } t_ccip_c0_rsp;

  typedef struct packed {
    t_ccip_vc     vc_sel;
    logic [1:0]   rsvd1;
    t_ccip_clLen  cl_len;
    t_ccip_c0_req req_type;
    logic [5:0]   rsvd0;
    t_ccip_clAddr address;
    t_ccip_mdata  mdata;
  } t_ccip_c0_ReqMemHdr;

  typedef struct packed {
    t_ccip_vc     vc_used;
    logic         rsvd1;
    logic         hit_miss;
    logic [1:0]   rsvd0;
    logic [1:0]   cl_num;
    t_ccip_c0_rsp resp_type;
    t_ccip_mdata  mdata;
  } t_ccip_c0_RspMemHdr;

  typedef struct packed {
    t_ccip_c0_ReqMemHdr hdr;
    logic               valid;
  } t_if_ccip_c0_Tx;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    logic [511:0]       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  // ---------------- NIC definitions ----------------
  typedef struct packed {
    logic [31:0] rpc_id;
    logic [31:0] fn_id;
    logic [63:0] arg0;
    logic [63:0] arg1;
  } RpcIf;

  localparam int SLOT_FLAG_BIT   = 511;
  localparam int MAX_OUTSTANDING = 8;

  typedef enum logic { RxIdle = 1'b0, RxPoll = 1'b1 } t_rx_state;

endpackage

// File: rtl/ccip_receiver_flow_tracker.sv
// rx_flow_tracker
//   Per-flow bookkeeping for the receiver: a pending bit per flow (a read is
//   in flight), the flag value expected for the next fresh RPC per flow, and
//   the total count of reads in flight.
// Ports
//   clk, reset        clock, synchronous active-high reset
//   issue_i/_flow_i   a read is being issued for issue_flow_i
//   release_i/_flow_i a valid response for release_flow_i is being retired
//   toggle_i          the retired response was fresh: flip its expected flag
//   pending_o         per-flow read-in-flight bits
//   exp_flag_o        per-flow expected slot flag (reset to all ones)
//   outstanding_o     reads in flight (0..8)
module rx_flow_tracker #(
  parameter int NFLOWS = 2,
  parameter int FW     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_i,
  input  logic [FW-1:0]     issue_flow_i,
  input  logic              release_i,
  input  logic [FW-1:0]     release_flow_i,
  input  logic              toggle_i,
  output logic [NFLOWS-1:0] pending_o,
  output logic [NFLOWS-1:0] exp_flag_o,
  output logic [3:0]        outstanding_o
);

  logic [NFLOWS-1:0] pending_q, pending_d;
  logic [NFLOWS-1:0] exp_q, exp_d;
  logic [3:0]        out_q, out_d;

  // Issue and release never target the same flow in one cycle (issue needs
  // pending=0, release needs pending=1), so the two updates are independent.
  // The issuer refuses at 8 in flight, which keeps out_q within 0..8.
  always_comb begin
    pending_d = pending_q;
    exp_d     = exp_q;
    out_d     = out_q;
    if (release_i) pending_d[release_flow_i] = 1'b0;
    if (issue_i)   pending_d[issue_flow_i]   = 1'b1;
    if (toggle_i)  exp_d[release_flow_i]     = ~exp_q[release_flow_i];
    case ({issue_i, release_i})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      exp_q     <= '1;
      out_q     <= '0;
    end else begin
      pending_q <= pending_d;
      exp_q     <= exp_d;
      out_q     <= out_d;
    end
  end

  assign pending_o     = pending_q;
  assign exp_flag_o    = exp_q;
  assign outstanding_o = out_q;

endmodule

// File: rtl/ccip_receiver.sv
// ccip_receiver
//   Polls one host-memory rx slot per flow over CCI-P c0 reads and delivers
//   each newly written RPC (slot flag toggled since the last delivery) as a
//   one-cycle strobe. At most one read per flow and 8 reads overall in flight.
// Ports
//   clk, reset             clock, synchronous active-high reset
//   number_of_flows        index of the last active flow
//   rx_base_addr           CL address of flow 0's slot (flow f at +f)
//   start                  enables polling
//   sRx_c0TxAlmFull        c0 request channel almost full
//   sTx_c0 / sRx_c0        c0 read requests / responses
//   rpc_out, rpc_valid_out, rpc_flow_id_out   delivered RPC strobe
//   error                  sticky: response with no matching read in flight
// Build option
//   CCIP_RX_STATS_EN adds stat_rpc_cnt / stat_stale_cnt (32-bit, wrapping)
//   counting delivered and stale responses.
// mdata[15:8] carries NIC_ID so host-side traces identify the NIC; this
// needs LMAX_NUM_OF_FLOWS <= 8.
module ccip_receiver
  import ccip_receiver_pkg::*;
#(
  parameter int NIC_ID            = 0,
  parameter int LMAX_NUM_OF_FLOWS = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  t_ccip_clAddr                 rx_base_addr,
  input  logic                         start,
  input  logic                         sRx_c0TxAlmFull,
  output t_if_ccip_c0_Tx               sTx_c0,
  input  t_if_ccip_c0_Rx               sRx_c0,
  output RpcIf                         rpc_out,
  output logic                         rpc_valid_out,
  output logic [LMAX_NUM_OF_FLOWS-1:0] rpc_flow_id_out,
  output logic                         error
`ifdef CCIP_RX_STATS_EN
  ,
  output logic [31:0]                  stat_rpc_cnt,
  output logic [31:0]                  stat_stale_cnt
`endif
);

  localparam int          MAX_RX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int          FW           = LMAX_NUM_OF_FLOWS;
  localparam logic [7:0]  NIC_TAG      = 8'(NIC_ID);

  t_rx_state          state_q, state_d;
  logic [FW-1:0]      poll_cnt_q, poll_cnt_d;
  t_if_ccip_c0_Tx     tx_q, tx_d;
  RpcIf               rpc_q, rpc_d;
  logic               rpc_vld_q;
  logic [FW-1:0]      rpc_flow_q, rpc_flow_d;
  logic               err_q, err_d;

  logic [MAX_RX_FLOWS-1:0] pending, exp_flag;
  logic [3:0]              outstanding;

  logic          issue;
  logic          rsp_acc, rsp_bad, rsp_ok, rsp_fresh;
  logic [FW-1:0] rsp_flow;

  // ---------------- poll FSM ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RxIdle:  if (start)  state_d = RxPoll;
      RxPoll:  if (!start) state_d = RxIdle;
      default: state_d = RxIdle;
    endcase
  end

  // Scan visits every flow once per round regardless of whether it issues;
  // >= also recovers if number_of_flows shrinks below the current position.
  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (state_q == RxPoll)
      poll_cnt_d = (poll_cnt_q >= number_of_flows) ? '0 : poll_cnt_q + 1'b1;
  end

  assign issue = (state_q == RxPoll) && !sRx_c0TxAlmFull && !pending[poll_cnt_q]
              && (outstanding < 4'(MAX_OUTSTANDING));

  always_comb begin
    tx_d              = '0;
    tx_d.valid        = issue;
    tx_d.hdr.vc_sel   = eVC_VH0;
    tx_d.hdr.cl_len   = eCL_LEN_1;
    tx_d.hdr.req_type = eREQ_RDLINE_I;
    tx_d.hdr.address  = rx_base_addr + t_ccip_clAddr'(poll_cnt_q);
    tx_d.hdr.mdata    = {NIC_TAG, 8'(poll_cnt_q)};
  end

  // ---------------- response path ----------------
  assign rsp_acc   = sRx_c0.rspValid && (sRx_c0.hdr.resp_type == eRSP_RDLINE);
  assign rsp_flow  = sRx_c0.hdr.mdata[FW-1:0];
  // A read response we never asked for (or lost across reset) must not
  // corrupt the counters.
  assign rsp_bad   = rsp_acc && (!pending[rsp_flow] || (outstanding == 4'd0));
  assign rsp_ok    = rsp_acc && !rsp_bad;
  assign rsp_fresh = rsp_ok && (sRx_c0.data[SLOT_FLAG_BIT] == exp_flag[rsp_flow]);

  always_comb begin
    rpc_d      = rpc_q;
    rpc_flow_d = rpc_flow_q;
    err_d      = err_q | rsp_bad;
    if (rsp_fresh) begin
      rpc_d      = RpcIf'(sRx_c0.data[$bits(RpcIf)-1:0]);
      rpc_flow_d = rsp_flow;
    end
  end

  rx_flow_tracker #(
    .NFLOWS (MAX_RX_FLOWS),
    .FW     (FW)
  ) u_trk (
    .clk            (clk),
    .reset          (reset),
    .issue_i        (issue),
    .issue_flow_i   (poll_cnt_q),
    .release_i      (rsp_ok),
    .release_flow_i (rsp_flow),
    .toggle_i       (rsp_fresh),
    .pending_o      (pending),
    .exp_flag_o     (exp_flag),
    .outstanding_o  (outstanding)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RxIdle;
      poll_cnt_q <= '0;
      tx_q       <= '0;
      rpc_q      <= '0;
      rpc_vld_q  <= 1'b0;
      rpc_flow_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      tx_q       <= tx_d;
      rpc_q      <= rpc_d;
      rpc_vld_q  <= rsp_fresh;
      rpc_flow_q <= rpc_flow_d;
      err_q      <= err_d;
    end
  end

  assign sTx_c0          = tx_q;
  assign rpc_out         = rpc_q;
  assign rpc_valid_out   = rpc_vld_q;
  assign rpc_flow_id_out = rpc_flow_q;
  assign error           = err_q;

`ifdef CCIP_RX_STATS_EN
  logic [31:0] stat_rpc_q, stat_stale_q;
  logic        rsp_stale;
  assign rsp_stale = rsp_ok && !rsp_fresh;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_rpc_q   <= '0;
      stat_stale_q <= '0;
    end else begin
      if (rsp_fresh) stat_rpc_q   <= stat_rpc_q + 32'd1;
      if (rsp_stale) stat_stale_q <= stat_stale_q + 32'd1;
    end
  end

  assign stat_rpc_cnt   = stat_rpc_q;
  assign stat_stale_cnt = stat_stale_q;
`endif

  // Header fields, upper mdata/data bits and MMIO strobes are not needed.
  logic unused_rx;
  assign unused_rx = ^{sRx_c0};

endmodule

// File: tb/tb_ccip_receiver.sv
// tb_ccip_receiver
//   Directed bench for ccip_receiver (LMAX_NUM_OF_FLOWS=2). A table of
//   {flow, slot flag, expected strobe} responses is replayed against a
//   two-flow poll loop, followed by hand-written sequences for ignored
//   responses, unexpected responses after reset, almost-full blocking,
//   the per-flow / overall in-flight limits and stopping with reads in flight.
module tb_ccip_receiver;
  import ccip_receiver_pkg::*;

  localparam int L = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [L-1:0]   number_of_flows;
  t_ccip_clAddr   rx_base_addr;
  logic           start;
  logic           alm_full;
  t_if_ccip_c0_Tx sTx_c0;
  t_if_ccip_c0_Rx sRx_c0;
  RpcIf           rpc_out;
  logic           rpc_valid_out;
  logic [L-1:0]   rpc_flow_id_out;
  logic           error;
`ifdef CCIP_RX_STATS_EN
  logic [31:0]    stat_rpc_cnt, stat_stale_cnt;
`endif

  ccip_receiver #(.NIC_ID(3), .LMAX_NUM_OF_FLOWS(L)) dut (
    .clk             (clk),
    .reset           (reset),
    .number_of_flows (number_of_flows),
    .rx_base_addr    (rx_base_addr),
    .start           (start),
    .sRx_c0TxAlmFull (alm_full),
    .sTx_c0          (sTx_c0),
    .sRx_c0          (sRx_c0),
    .rpc_out         (rpc_out),
    .rpc_valid_out   (rpc_valid_out),
    .rpc_flow_id_out (rpc_flow_id_out),
    .error           (error)
`ifdef CCIP_RX_STATS_EN
    ,
    .stat_rpc_cnt    (stat_rpc_cnt),
    .stat_stale_cnt  (stat_stale_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- request monitor / in-flight model ----------------
  int inflight[4];
  int nreq = 0;
  int last_flow = 0;
  int peak = 0;
  int mf, msum;
  bit no_req_window = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) inflight[i] = 0;
    end else begin
      if (sRx_c0.rspValid && sRx_c0.hdr.resp_type == eRSP_RDLINE &&
          inflight[int'(sRx_c0.hdr.mdata[L-1:0])] > 0)
        inflight[int'(sRx_c0.hdr.mdata[L-1:0])]--;
      if (sTx_c0.valid) begin
        mf = int'(sTx_c0.hdr.mdata[L-1:0]);
        nreq++;
        last_flow = mf;
        check("one_read_per_flow", 256'(inflight[mf]), 256'd0);
        check("rd_addr", 256'(sTx_c0.hdr.address), 256'(rx_base_addr + 42'(mf)));
        check("rd_hdr", {sTx_c0.hdr.vc_sel, sTx_c0.hdr.cl_len, sTx_c0.hdr.req_type},
              {eVC_VH0, eCL_LEN_1, eREQ_RDLINE_I});
        check("no_req_when_stopped", 256'(no_req_window), 256'd0);
        inflight[mf]++;
        msum = 0;
        for (int i = 0; i < 4; i++) msum += inflight[i];
        if (msum > peak) peak = msum;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic RpcIf pay(input int i);
    RpcIf r;
    r.rpc_id = 32'(i);
    r.fn_id  = 32'hF00D_0000 + 32'(i);
    r.arg0   = {32'hDEAD_BEEF, 32'(i)};
    r.arg1   = ~{32'(i), 32'h1234_5678};
    return r;
  endfunction

  task automatic respond(input int f, input logic flag, input RpcIf p);
    sRx_c0                          = '0;
    sRx_c0.hdr.resp_type            = eRSP_RDLINE;
    sRx_c0.hdr.mdata                = 16'(f);
    sRx_c0.data[SLOT_FLAG_BIT]      = flag;
    sRx_c0.data[$bits(RpcIf)-1:0]   = p;
    sRx_c0.rspValid                 = 1'b1;
    tick();
    sRx_c0 = '0;
  endtask

  task automatic wait_req(input int target, input int budget);
    int k;
    k = 0;
    while (nreq < target && k < budget) begin
      tick();
      k++;
    end
    if (nreq < target) check("wait_req_timeout", 256'(nreq), 256'(target));
  endtask

  typedef struct {
    int   flow;
    logic flag;
    logic exp_v;
  } vec_t;

  vec_t tbl[8];
  int   base;
  RpcIf p;

  initial begin
    // expected flags start at 1/1 and flip on each delivery
    tbl[0] = '{1, 1'b1, 1'b1};  // exp1 -> 0
    tbl[1] = '{1, 1'b1, 1'b0};  // stale
    tbl[2] = '{0, 1'b0, 1'b0};  // stale (exp0 = 1)
    tbl[3] = '{0, 1'b1, 1'b1};  // exp0 -> 0
    tbl[4] = '{1, 1'b0, 1'b1};  // exp1 -> 1
    tbl[5] = '{0, 1'b0, 1'b1};  // exp0 -> 1
    tbl[6] = '{1, 1'b1, 1'b1};  // exp1 -> 0
    tbl[7] = '{1, 1'b1, 1'b0};  // stale

    reset           = 1'b1;
    start           = 1'b0;
    alm_full        = 1'b0;
    number_of_flows = 2'd1;
    rx_base_addr    = 42'h0_1234_5000;
    sRx_c0          = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // ---- reset state ----
    check("rst_tx_valid",  256'(sTx_c0.valid),    256'd0);
    check("rst_rpc_valid", 256'(rpc_valid_out),   256'd0);
    check("rst_rpc_out",   256'(rpc_out),         256'd0);
    check("rst_flow_id",   256'(rpc_flow_id_out), 256'd0);
    check("rst_error",     256'(error),           256'd0);

    // ---- two flows: one read each, then nothing while both pending ----
    start = 1'b1;
    wait_req(2, 20);
    repeat (5) tick();
    check("two_reads_only", 256'(nreq), 256'd2);

    // ---- response table ----
    for (int i = 0; i < 8; i++) begin
      base = nreq;
      p    = pay(i);
      respond(tbl[i].flow, tbl[i].flag, p);
      check("rpc_valid", 256'(rpc_valid_out), 256'(tbl[i].exp_v));
      if (tbl[i].exp_v) begin
        check("rpc_flow", 256'(rpc_flow_id_out), 256'(tbl[i].flow));
        check("rpc_data", 256'(rpc_out), 256'(p));
      end
      check("no_error", 256'(error), 256'd0);
      if (i == 0) begin
        tick();
        check("strobe_one_cycle", 256'(rpc_valid_out), 256'd0);
      end
      wait_req(base + 1, 20);
      check("reissue_flow", 256'(last_flow), 256'(tbl[i].flow));
    end

    // ---- non-RDLINE traffic is ignored (flag 0 would be fresh on flow 1) ----
    sRx_c0                     = '0;
    sRx_c0.hdr.resp_type       = eRSP_UMSG;
    sRx_c0.hdr.mdata           = 16'd1;
    sRx_c0.rspValid            = 1'b1;
    tick();
    sRx_c0                     = '0;
    sRx_c0.hdr.mdata           = 16'd1;
    sRx_c0.mmioRdValid         = 1'b1;
    tick();
    sRx_c0 = '0;
    tick();
    check("ignored_rpc_valid", 256'(rpc_valid_out), 256'd0);
    check("ignored_error",     256'(error),         256'd0);

    // ---- unchanged slot polled 5 times: all stale (exp0 = 1) ----
    for (int i = 0; i < 5; i++) begin
      base = nreq;
      respond(0, 1'b0, pay(100 + i));
      check("stale_rpc_valid", 256'(rpc_valid_out), 256'd0);
      wait_req(base + 1, 20);
    end
`ifdef CCIP_RX_STATS_EN
    check("stat_rpc",   256'(stat_rpc_cnt),   256'd5);
    check("stat_stale", 256'(stat_stale_cnt), 256'd8);
`endif

    // ---- reset mid-operation, then a late response for flow 0 ----
    start = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst2_error", 256'(error), 256'd0);
    respond(0, 1'b1, pay(50));
    check("bogus_error",     256'(error),         256'd1);
    check("bogus_rpc_valid", 256'(rpc_valid_out), 256'd0);
    tick();
    check("error_sticky", 256'(error), 256'd1);

    // ---- four flows, almost full held for 20 cycles ----
    reset           = 1'b1;
    alm_full        = 1'b1;
    number_of_flows = 2'd3;
    start           = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    peak  = 0;
    base  = nreq;
    repeat (20) tick();
    check("almfull_no_reads", 256'(nreq - base), 256'd0);
    alm_full = 1'b0;
    tick();
    check("resume_next_cycle", 256'(sTx_c0.valid), 256'd1);
    wait_req(base + 4, 30);
    repeat (10) tick();
    check("four_reads_only", 256'(nreq - base), 256'd4);
    check("peak_outstanding", 256'(peak), 256'd4);

    // ---- stop with reads in flight; all still delivered ----
    start = 1'b0;
    repeat (2) tick();
    no_req_window = 1'b1;
    base = nreq;
    for (int f = 0; f < 4; f++) begin
      p = pay(200 + f);
      respond(f, 1'b1, p);
      check("drain_rpc_valid", 256'(rpc_valid_out),   256'd1);
      check("drain_rpc_flow",  256'(rpc_flow_id_out), 256'(f));
      check("drain_rpc_data",  256'(rpc_out),         256'(p));
      repeat (2) tick();
    end
    repeat (5) tick();
    check("drain_no_reads", 256'(nreq - base), 256'd0);
    msum = 0;
    for (int i = 0; i < 4; i++) msum += inflight[i];
    check("drain_model_zero", 256'(msum), 256'd0);
    check("drain_error", 256'(error), 256'd0);

    // restart: every flow must be free to issue again
    no_req_window = 1'b0;
    start = 1'b1;
    wait_req(base + 4, 30);
    check("restart_error", 256'(error), 256'd0);
    start = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
